// File: rtl/jzjpcc_fetch_controller_if.sv
// Fetch controller bus: pipeline/memory control inputs and fetch/decode status outputs.
interface jzjpcc_fetch_controller_if #(
  parameter int unsigned PC_MAX_B = 15
);
  logic                pcCTWriteEnable;
  logic [PC_MAX_B:2]   controlTransferNewPC;
  logic                hazardStall;
  logic                imemReady;
  logic                haltRequest;
  logic [PC_MAX_B:2]   fetchPC;
  logic                fetchRequest;
  logic [PC_MAX_B:2]   currentPC_decode;
  logic                decodeValid;
  logic                flushDecode;
  logic                halted;
  logic [31:0]         redirectCount;

  // Fetch controller side.
  modport master (
    input  pcCTWriteEnable, controlTransferNewPC, hazardStall, imemReady, haltRequest,
    output fetchPC, fetchRequest, currentPC_decode, decodeValid, flushDecode, halted,
           redirectCount
  );

  // Pipeline / instruction-memory side.
  modport slave (
    output pcCTWriteEnable, controlTransferNewPC, hazardStall, imemReady, haltRequest,
    input  fetchPC, fetchRequest, currentPC_decode, decodeValid, flushDecode, halted,
           redirectCount
  );
endinterface

// File: rtl/jzjpcc_fetch_controller.sv
// Fetch controller: sequences the word-indexed fetch PC, handles decode-stage
// redirects, load-use stalls, instruction-memory wait states and halt.
module jzjpcc_fetch_controller #(
  parameter int unsigned PC_MAX_B = 15,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                          clock,
  input  logic                          reset,
  jzjpcc_fetch_controller_if.master     bus
);
  localparam int unsigned W = PC_MAX_B - 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_fetch_pc;
  logic [W-1:0]  r_cur_pc;
  logic          r_decode_valid;
  logic          r_halted;
  logic [31:0]   r_redirect_cnt;

  logic          w_run;
  logic          w_take_halt;
  logic          w_take_stall;
  logic          w_take_redir;

  // Per-cycle action select; decode-stage requests only count with a real instruction in decode.
  always_comb begin
    w_run        = (r_state == ST_RUN);
    w_take_halt  = w_run & r_decode_valid & bus.haltRequest;
    w_take_stall = w_run & r_decode_valid & bus.hazardStall & ~w_take_halt;
    w_take_redir = w_run & r_decode_valid & bus.pcCTWriteEnable & ~w_take_halt & ~w_take_stall;
  end

  // State machine and PC/decode registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_fetch_pc     <= RESET_PC[PC_MAX_B:2];
      r_cur_pc       <= '0;
      r_decode_valid <= 1'b0;
      r_halted       <= 1'b0;
      r_redirect_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_take_halt) begin
        r_state        <= ST_HALTED;
        r_halted       <= 1'b1;
        r_decode_valid <= 1'b0;
      end else if (w_take_stall) begin
        r_state <= ST_RUN;
      end else if (w_take_redir) begin
        r_fetch_pc     <= bus.controlTransferNewPC;
        r_decode_valid <= 1'b0;
        r_redirect_cnt <= r_redirect_cnt + 32'(1);
      end else if (!bus.imemReady) begin
        r_decode_valid <= 1'b0;
      end else begin
        r_cur_pc       <= r_fetch_pc;
        r_decode_valid <= 1'b1;
        r_fetch_pc     <= r_fetch_pc + W'(1);
      end
    end
  end

  // Combinational handshake outputs; everything else comes straight from registers.
  assign bus.fetchRequest     = w_run & ~w_take_halt & ~w_take_stall;
  assign bus.flushDecode      = w_take_redir;
  assign bus.fetchPC          = r_fetch_pc;
  assign bus.currentPC_decode = r_cur_pc;
  assign bus.decodeValid      = r_decode_valid;
  assign bus.halted           = r_halted;
  assign bus.redirectCount    = r_redirect_cnt;
endmodule

// File: tb/tb_jzjpcc_fetch_controller.sv
// Self-checking bench for jzjpcc_fetch_controller: directed scenarios plus
// randomized traffic checked against a behavioural model every cycle.
module tb_jzjpcc_fetch_controller;
  localparam int unsigned PC_MAX_B = 15;
  localparam int unsigned W        = PC_MAX_B - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  jzjpcc_fetch_controller_if #(.PC_MAX_B(PC_MAX_B)) bus ();

  jzjpcc_fetch_controller #(.PC_MAX_B(PC_MAX_B), .RESET_PC(32'h00000000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model of the architectural state.
  logic [W-1:0] m_fetch;
  logic [W-1:0] m_cpd;
  logic         m_dv;
  logic         m_halted;
  logic [31:0]  m_cnt;
  logic         m_known = 1'b0;

  // Last sampled combinational outputs, for literal checks.
  logic l_flush;
  logic l_freq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Decode-stage requests only matter when decode holds a real instruction.
  function automatic logic decode_req(input logic r);
    return !m_halted && m_dv && r;
  endfunction

  function automatic logic exp_fetch_req();
    if (m_halted) return 1'b0;
    return !(decode_req(bus.haltRequest) || decode_req(bus.hazardStall));
  endfunction

  function automatic logic exp_flush();
    return decode_req(bus.pcCTWriteEnable) && !bus.haltRequest && !bus.hazardStall;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_fetch = '0; m_cpd = '0; m_dv = 1'b0; m_halted = 1'b0; m_cnt = '0;
      m_known = 1'b1;
    end else if (m_halted) begin
      // frozen
    end else if (decode_req(bus.haltRequest)) begin
      m_halted = 1'b1; m_dv = 1'b0;
    end else if (decode_req(bus.hazardStall)) begin
      // everything holds
    end else if (decode_req(bus.pcCTWriteEnable)) begin
      m_fetch = bus.controlTransferNewPC; m_dv = 1'b0; m_cnt = m_cnt + 1;
    end else if (!bus.imemReady) begin
      m_dv = 1'b0;
    end else begin
      m_cpd = m_fetch; m_dv = 1'b1; m_fetch = m_fetch + 1'b1;
    end
  endtask

  task automatic check_all();
    chk("fetchPC", 32'(bus.fetchPC), 32'(m_fetch));
    chk("currentPC_decode", 32'(bus.currentPC_decode), 32'(m_cpd));
    chk("decodeValid", 32'(bus.decodeValid), 32'(m_dv));
    chk("halted", 32'(bus.halted), 32'(m_halted));
    chk("redirectCount", bus.redirectCount, m_cnt);
    if (!reset) begin
      chk("fetchRequest", 32'(bus.fetchRequest), 32'(exp_fetch_req()));
      chk("flushDecode", 32'(bus.flushDecode), 32'(exp_flush()));
    end
  endtask

  // One clock: drive at negedge, compare, then advance the model at the rising edge.
  task automatic step(input logic rst, input logic hs, input logic ct,
                      input logic [W-1:0] tgt, input logic hr, input logic ir);
    @(negedge clock);
    reset = rst;
    bus.hazardStall = hs;
    bus.pcCTWriteEnable = ct;
    bus.controlTransferNewPC = tgt;
    bus.haltRequest = hr;
    bus.imemReady = ir;
    #1;
    l_flush = bus.flushDecode;
    l_freq  = bus.fetchRequest;
    if (m_known) check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, act, exp);
  endtask

  initial begin
    reset = 1'b1;
    bus.hazardStall = 1'b0; bus.pcCTWriteEnable = 1'b0; bus.controlTransferNewPC = '0;
    bus.haltRequest = 1'b0; bus.imemReady = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    lit("rst_fetch", 32'(bus.fetchPC), 32'h0);
    lit("rst_dv", 32'(bus.decodeValid), 32'h0);
    lit("rst_halted", 32'(bus.halted), 32'h0);
    lit("rst_cnt", bus.redirectCount, 32'h0);

    // Sequential fetch from reset.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (i == 0) lit("first_req", 32'(l_freq), 32'h1);
      lit("seq_fetch", 32'(bus.fetchPC), 32'(i + 1));
      lit("seq_cpd", 32'(bus.currentPC_decode), 32'(i));
      lit("seq_dv", 32'(bus.decodeValid), 32'h1);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    lit("pre_br_cpd", 32'(bus.currentPC_decode), 32'h5);

    // Taken branch from PC 5 to 0x40 while memory is not ready.
    step(0, 0, 1, W'(14'h40), 0, 0);
    lit("br_flush", 32'(l_flush), 32'h1);
    lit("br_fetch", 32'(bus.fetchPC), 32'h40);
    lit("br_dv", 32'(bus.decodeValid), 32'h0);
    lit("br_cnt", bus.redirectCount, 32'h1);
    step(0, 0, 0, 0, 0, 1);
    lit("br_flush_off", 32'(l_flush), 32'h0);
    lit("br_seq_cpd", 32'(bus.currentPC_decode), 32'h40);
    lit("br_seq_fetch", 32'(bus.fetchPC), 32'h41);

    // Stall masks a pending redirect.
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, W'(14'h80), 0, 1);
      lit("stall_flush", 32'(l_flush), 32'h0);
      lit("stall_req", 32'(l_freq), 32'h0);
      lit("stall_fetch", 32'(bus.fetchPC), 32'h41);
      lit("stall_cpd", 32'(bus.currentPC_decode), 32'h40);
      lit("stall_cnt", bus.redirectCount, 32'h1);
    end
    step(0, 0, 1, W'(14'h80), 0, 1);
    lit("post_stall_flush", 32'(l_flush), 32'h1);
    lit("post_stall_fetch", 32'(bus.fetchPC), 32'h80);
    lit("post_stall_cnt", bus.redirectCount, 32'h2);

    // Redirect to 7, then memory wait states.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, W'(7), 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      lit("wait_fetch", 32'(bus.fetchPC), 32'h7);
      lit("wait_dv", 32'(bus.decodeValid), 32'h0);
    end
    step(0, 0, 0, 0, 0, 1);
    lit("ready_cpd", 32'(bus.currentPC_decode), 32'h7);
    lit("ready_fetch", 32'(bus.fetchPC), 32'h8);

    // Halt: everything frozen regardless of inputs.
    step(0, 0, 0, 0, 1, 1);
    lit("halt_halted", 32'(bus.halted), 32'h1);
    lit("halt_dv", 32'(bus.decodeValid), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      lit("halt_req", 32'(l_freq), 32'h0);
      lit("halt_flush", 32'(l_flush), 32'h0);
    end
    lit("halt_fetch", 32'(bus.fetchPC), 32'h8);
    lit("halt_cpd", 32'(bus.currentPC_decode), 32'h7);
    lit("halt_cnt", bus.redirectCount, 32'h3);
    step(1, 0, 0, 0, 0, 1);
    lit("unhalt_fetch", 32'(bus.fetchPC), 32'h0);
    lit("unhalt_cnt", bus.redirectCount, 32'h0);
    lit("unhalt_halted", 32'(bus.halted), 32'h0);

    // PC wrap from all-ones.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, W'(14'h3FFF), 0, 1);
    step(0, 0, 0, 0, 0, 1);
    lit("wrap_fetch", 32'(bus.fetchPC), 32'h0);
    lit("wrap_cpd", 32'(bus.currentPC_decode), 32'h3FFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic rst, hs, ct, hr, ir;
      logic [W-1:0] tgt;
      rst = ($urandom_range(0, 199) == 0);
      hs  = ($urandom_range(0, 99) < 15);
      ct  = ($urandom_range(0, 99) < 20);
      hr  = ($urandom_range(0, 99) == 0);
      ir  = ($urandom_range(0, 99) < 80);
      tgt = ($urandom_range(0, 7) == 0) ? W'(14'h3FFF) : W'($urandom);
      step(rst, hs, ct, tgt, hr, ir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
